// File: rtl/noise_sched_pkg.sv
// Shared types and constants for the noise channel scheduler: FSM states,
// gain Q-format and default sample saturation limits.
package noise_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StCapture,
        StOffer,
        StDone
    } state_e;

    localparam int unsigned SAMPLE_W  = 18;
    localparam int unsigned GAIN_FRAC = 14;
    localparam int          GAIN_ONE  = 1 << GAIN_FRAC;
    localparam int          SAT_MAX   = (1 << (SAMPLE_W - 1)) - 1;
    localparam int          SAT_MIN   = -(1 << (SAMPLE_W - 1));

endpackage

// File: rtl/noise_gain_sat.sv
// Combinational signed sample x Q(FRAC) gain: full-width product, arithmetic
// shift right by FRAC (floor), then saturate to the signed WIDTH range.
module noise_gain_sat #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] gain,
    output logic signed [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] MAX_V = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [PW-1:0] sample_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;

    always_comb begin
        sample_x = $signed({{WIDTH{sample[WIDTH-1]}}, sample});
        gain_x   = $signed({{WIDTH{gain[WIDTH-1]}}, gain});
        // The exact product of two WIDTH-bit values always fits in 2*WIDTH bits.
        product  = sample_x * gain_x;
        shifted  = product >>> FRAC;
        if (shifted > MAX_V) begin
            result = MAX_V[WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[WIDTH-1:0];
        end else begin
            result = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/noise_channel_scheduler.sv
// Time-shares one noise generator across NCH channels: per tick, one round in
// ascending order over the enabled channels with gain scaling and timed handshake.
module noise_channel_scheduler
    import noise_sched_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned WIDTH   = SAMPLE_W,
    parameter int unsigned FRAC    = GAIN_FRAC,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic [NCH-1:0]          ch_enable,
    input  logic [NCH*WIDTH-1:0]    ch_gain,
    output logic                    gen_clk_en,
    input  logic signed [WIDTH-1:0] gen_noise,
    output logic [WIDTH-1:0]        ch_data,
    output logic [NCH-1:0]          ch_valid,
    input  logic [NCH-1:0]          ch_ready,
    output logic                    busy,
    output logic                    round_done,
    output logic                    overrun,
    output logic [NCH-1:0]          drop_flags,
    input  logic                    clear_flags
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [NCH-1:0]       en_q, en_d;
    logic [NCH*WIDTH-1:0] gain_q, gain_d;
    logic [CW-1:0]        cur_q, cur_d;
    logic [TW-1:0]        wait_q, wait_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 overrun_q, overrun_d;
    logic [NCH-1:0]       drop_q, drop_d;

    logic signed [WIDTH-1:0] gain_arr [NCH];
    logic signed [WIDTH-1:0] cur_gain;
    logic signed [WIDTH-1:0] scaled;
    logic                    start;
    logic                    advance;
    logic [CW:0]             nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_gain
        assign gain_arr[g] = gain_q[g*WIDTH +: WIDTH];
    end

    assign cur_gain = gain_arr[cur_q];

    noise_gain_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_gain_sat (
        .sample (gen_noise),
        .gain   (cur_gain),
        .result (scaled)
    );

    // Returns {found, index} of the lowest set bit of mask at or above lo.
    function automatic logic [CW:0] first_from(input logic [NCH-1:0] mask, input int lo);
        logic [CW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) begin
                r = {1'b1, CW'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        en_d      = en_q;
        gain_d    = gain_q;
        cur_d     = cur_q;
        wait_d    = wait_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        start     = 1'b0;
        advance   = 1'b0;
        nxt       = '0;

        // Clear first so that any set below in the same cycle takes priority.
        if (clear_flags) begin
            overrun_d = 1'b0;
            drop_d    = '0;
        end

        unique case (state_q)
            StIdle: begin
                start = sample_tick | pending_q;
            end
            StStep: begin
                state_d = StCapture;
            end
            StCapture: begin
                data_d  = scaled;
                wait_d  = '0;
                state_d = StOffer;
            end
            StOffer: begin
                if (ch_ready[cur_q]) begin
                    advance = 1'b1;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    advance       = 1'b1;
                    drop_d[cur_q] = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (advance) begin
                    nxt = first_from(en_q, int'(cur_q) + 1);
                    if (nxt[CW]) begin
                        cur_d   = nxt[CW-1:0];
                        state_d = StStep;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (pending_q) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // One-deep tick queue; a pending tick consumed in DONE frees the slot.
        if (state_q == StIdle) begin
            if (start) begin
                pending_d = 1'b0;
            end
        end else if (state_q == StDone && pending_q) begin
            pending_d = sample_tick;
        end else if (sample_tick) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (start) begin
            en_d   = ch_enable;
            gain_d = ch_gain;
            nxt    = first_from(ch_enable, 0);
            if (nxt[CW]) begin
                cur_d   = nxt[CW-1:0];
                state_d = StStep;
            end else begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            en_q      <= '0;
            gain_q    <= '0;
            cur_q     <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            gain_q    <= gain_d;
            cur_q     <= cur_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    // Strobes and valid decode straight from state so reset removes them at once.
    always_comb begin
        gen_clk_en = (state_q == StStep);
        busy       = (state_q != StIdle);
        round_done = (state_q == StDone);
        ch_valid   = '0;
        if (state_q == StOffer) begin
            ch_valid[cur_q] = 1'b1;
        end
        ch_data    = data_q;
        overrun    = overrun_q;
        drop_flags = drop_q;
    end

endmodule

// File: tb/tb_noise_channel_scheduler.sv
// Scoreboard bench: a generator model feeds queued noise, expected scaled samples are
// queued when stimulus is set up and compared as the DUT hands them over.
module tb_noise_channel_scheduler;
    import noise_sched_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 18;

    typedef struct {
        int ch;
        int data;
        int cyc;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    sample_tick = 1'b0;
    logic [NCH-1:0]          ch_enable = '0;
    logic [NCH*W-1:0]        ch_gain = '0;
    logic                    gen_clk_en;
    logic signed [W-1:0]     gen_noise;
    logic [W-1:0]            ch_data;
    logic [NCH-1:0]          ch_valid;
    logic [NCH-1:0]          ch_ready = '1;
    logic                    busy;
    logic                    round_done;
    logic                    overrun;
    logic [NCH-1:0]          drop_flags;
    logic                    clear_flags = 1'b0;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    int   vcnt [NCH];
    int   gen_cyc[$];
    int   done_cyc[$];
    int   noise_q[$];
    exp_t exp_q[$];

    noise_channel_scheduler #(
        .NCH     (NCH),
        .WIDTH   (W),
        .FRAC    (14),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .ch_enable   (ch_enable),
        .ch_gain     (ch_gain),
        .gen_clk_en  (gen_clk_en),
        .gen_noise   (gen_noise),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .busy        (busy),
        .round_done  (round_done),
        .overrun     (overrun),
        .drop_flags  (drop_flags),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: registered, advances on the edge where gen_clk_en is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_noise <= '0;
        end else if (gen_clk_en) begin
            if (noise_q.size() > 0) gen_noise <= W'(noise_q.pop_front());
            else gen_noise <= '0;
        end
    end

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int model(input int noise, input int gain);
        longint p;
        p = longint'(noise) * longint'(gain);
        p = p >>> 14;
        if (p > longint'(SAT_MAX)) p = longint'(SAT_MAX);
        if (p < longint'(SAT_MIN)) p = longint'(SAT_MIN);
        return int'(p);
    endfunction

    function automatic int at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic push_exp(input int ch, input int noise, input int gain, input int c);
        noise_q.push_back(noise);
        exp_q.push_back('{ch, model(noise, gain), c});
    endtask

    task automatic set_gain(input int ch, input int g);
        ch_gain[ch*W +: W] = W'(g);
    endtask

    task automatic start_round();
        for (int i = 0; i < NCH; i++) vcnt[i] = 0;
        gen_cyc.delete();
        done_cyc.delete();
        done_base = done_cnt;
        @(posedge clk);
        #1 sample_tick = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic wait_rounds(input int n, input int budget);
        for (int i = 0; i < budget && done_cnt < done_base + n; i++) @(posedge clk);
        check("round_wait", int'(done_cnt >= done_base + n), 1);
        check("sb_left", exp_q.size(), 0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (gen_clk_en) gen_cyc.push_back(cyc - t0);
            if (round_done) begin
                done_cyc.push_back(cyc - t0);
                done_cnt++;
            end
            for (int i = 0; i < NCH; i++) if (ch_valid[i]) vcnt[i]++;
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", i, -1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("xfer_ch", i, e.ch);
                        check("xfer_data", int'($signed(ch_data)), e.data);
                        if (e.cyc >= 0) check("xfer_cyc", cyc - t0, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        check("rst_valid", int'(ch_valid), 0);
        check("rst_gen_en", int'(gen_clk_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(ch_data), 0);
        check("rst_flags", int'({overrun, drop_flags, round_done}), 0);
        #1 rst = 1'b0;

        // Basic round: channels 0 and 2, gains 1.0 and 0.5.
        ch_enable = 4'b0101;
        set_gain(0, GAIN_ONE);
        set_gain(2, 8192);
        push_exp(0, 1000, GAIN_ONE, 3);
        push_exp(2, 1000, 8192, 6);
        start_round();
        wait_rounds(1, 30);
        check("basic_gen_n", gen_cyc.size(), 2);
        check("basic_gen0", at(gen_cyc, 0), 1);
        check("basic_gen1", at(gen_cyc, 1), 4);
        check("basic_done", at(done_cyc, 0), 7);

        // Saturation at both rails.
        ch_enable = 4'b0011;
        set_gain(0, 131071);
        set_gain(1, 131071);
        push_exp(0, 20000, 131071, 3);
        push_exp(1, -20000, 131071, 6);
        start_round();
        wait_rounds(1, 30);

        // Timeout on channel 0, channel 1 still served.
        ch_enable = 4'b0011;
        ch_ready  = 4'b1110;
        set_gain(0, GAIN_ONE);
        set_gain(1, 4096);
        noise_q.push_back(777);
        push_exp(1, -3000, 4096, 21);
        start_round();
        wait_rounds(1, 60);
        check("to_valid_cycles", vcnt[0], 16);
        check("to_drop", int'(drop_flags), 1);
        check("to_next_gen", at(gen_cyc, 1), 19);
        check("to_done", at(done_cyc, 0), 22);
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        check("to_clear", int'(drop_flags), 0);
        ch_ready = '1;

        // Backpressure on channel 1: ready arrives after five waiting cycles.
        ch_enable = 4'b0010;
        ch_ready  = 4'b1101;
        set_gain(1, 24576);
        push_exp(1, 2222, 24576, 8);
        start_round();
        for (int i = 0; i < 10 && !ch_valid[1]; i++) @(negedge clk);
        check("bp_valid_seen", int'(ch_valid[1]), 1);
        d0 = int'(ch_data);
        for (int i = 0; i < 5; i++) begin
            check("bp_data_hold", int'(ch_data), d0);
            check("bp_valid_hold", int'(ch_valid), 2);
            @(posedge clk);
        end
        #1 ch_ready = '1;
        wait_rounds(1, 30);
        check("bp_no_drop", int'(drop_flags), 0);
        check("bp_done", at(done_cyc, 0), 9);

        // Overrun: three ticks inside one four-channel round.
        ch_enable = 4'b1111;
        for (int i = 0; i < NCH; i++) set_gain(i, GAIN_ONE - 1024 * i);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NCH; i++)
                push_exp(i, 100 * (r * NCH + i) - 350, GAIN_ONE - 1024 * i, (r == 0) ? 3 + 3 * i : -1);
        start_round();
        pulse_tick();
        pulse_tick();
        wait_rounds(2, 80);
        repeat (5) @(posedge clk);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_done_n", done_cyc.size(), 2);
        check("ovr_done0", at(done_cyc, 0), 13);
        check("ovr_round2_gen", at(gen_cyc, 4), 14);
        check("ovr_done1", at(done_cyc, 1), 26);
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        check("ovr_clear", int'(overrun), 0);

        // Reset during OFFER, then an empty-mask round.
        ch_enable = 4'b0001;
        ch_ready  = 4'b0000;
        noise_q.push_back(5000);
        start_round();
        for (int i = 0; i < 10 && !ch_valid[0]; i++) @(negedge clk);
        check("rst_offer_seen", int'(ch_valid[0]), 1);
        rst = 1'b1;
        #1;
        check("arst_valid", int'(ch_valid), 0);
        check("arst_gen_en", int'(gen_clk_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_data", int'(ch_data), 0);
        check("arst_done", int'(round_done), 0);
        noise_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        ch_ready = '1;
        repeat (3) @(posedge clk);
        check("arst_no_done", done_cnt, done_base);
        ch_enable = '0;
        start_round();
        wait_rounds(1, 10);
        check("empty_done", at(done_cyc, 0), 1);
        check("empty_gen_n", gen_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
